// File: rtl/fft8_loader_if.sv
// fft8_loader_if: sample stream and parallel frame bus for fft8_loader.
//   din_valid/din_real/din_imag/din_last : streaming complex input samples
//   en                                   : one-cycle launch pulse, new frame on x0..x7
//   x0..x7_real/imag                     : frame samples in natural order
//   frame_err                            : one-cycle framing-violation pulse
// Modports: master = upstream source / frame consumer, slave = the loader.
interface fft8_loader_if #(
    parameter int DW = 24
);
    logic          din_valid;
    logic [DW-1:0] din_real;
    logic [DW-1:0] din_imag;
    logic          din_last;
    logic          en;
    logic          frame_err;
    logic [DW-1:0] x0_real, x1_real, x2_real, x3_real;
    logic [DW-1:0] x4_real, x5_real, x6_real, x7_real;
    logic [DW-1:0] x0_imag, x1_imag, x2_imag, x3_imag;
    logic [DW-1:0] x4_imag, x5_imag, x6_imag, x7_imag;

    modport master (
        output din_valid, din_real, din_imag, din_last,
        input  en, frame_err,
        input  x0_real, x1_real, x2_real, x3_real, x4_real, x5_real, x6_real, x7_real,
        input  x0_imag, x1_imag, x2_imag, x3_imag, x4_imag, x5_imag, x6_imag, x7_imag
    );

    modport slave (
        input  din_valid, din_real, din_imag, din_last,
        output en, frame_err,
        output x0_real, x1_real, x2_real, x3_real, x4_real, x5_real, x6_real, x7_real,
        output x0_imag, x1_imag, x2_imag, x3_imag, x4_imag, x5_imag, x6_imag, x7_imag
    );
endinterface

// File: rtl/fft8_loader.sv
// fft8_loader: streaming input stage for the 8-point parallel FFT core.
// Collects eight accepted complex samples into a frame and presents them,
// held stable, on x0..x7 with a one-cycle en launch pulse. Checks framing
// against din_last and flags violations on frame_err.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : fft8_loader_if.slave (din_* stream in, en/x0..x7/frame_err out)
// Optional feature macro: FFT8_LOADER_SCALE_EN -- arithmetic right shift by 3
// of each component as it is written, so the 3-stage FFT cannot overflow.
module fft8_loader #(
    parameter int DW = 24
) (
    input  logic           clk,
    input  logic           rstn,
    fft8_loader_if.slave   bus
);

    logic [2:0]    wr_cnt_q, wr_cnt_d;
    logic [DW-1:0] buf_real_q [0:6];
    logic [DW-1:0] buf_real_d [0:6];
    logic [DW-1:0] buf_imag_q [0:6];
    logic [DW-1:0] buf_imag_d [0:6];
    logic [DW-1:0] x_real_q   [0:7];
    logic [DW-1:0] x_real_d   [0:7];
    logic [DW-1:0] x_imag_q   [0:7];
    logic [DW-1:0] x_imag_d   [0:7];
    logic          en_q, en_d;
    logic          frame_err_q, frame_err_d;

    logic [DW-1:0] smp_real;
    logic [DW-1:0] smp_imag;

    // Optional pre-scaling applied on the way into the buffer.
    always_comb begin
`ifdef FFT8_LOADER_SCALE_EN
        smp_real = DW'($signed(bus.din_real) >>> 3);
        smp_imag = DW'($signed(bus.din_imag) >>> 3);
`else
        smp_real = bus.din_real;
        smp_imag = bus.din_imag;
`endif
    end

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        buf_real_d  = buf_real_q;
        buf_imag_d  = buf_imag_q;
        x_real_d    = x_real_q;
        x_imag_d    = x_imag_q;
        en_d        = 1'b0;
        frame_err_d = 1'b0;

        if (bus.din_valid) begin
            if (wr_cnt_q == 3'd7) begin
                // The 8th sample bypasses the buffer straight into x7 so the
                // whole frame is transferred on the accepting edge.
                for (int unsigned i = 0; i < 7; i++) begin
                    x_real_d[i] = buf_real_q[i];
                    x_imag_d[i] = buf_imag_q[i];
                end
                x_real_d[7] = smp_real;
                x_imag_d[7] = smp_imag;
                en_d        = 1'b1;
                frame_err_d = ~bus.din_last;
                wr_cnt_d    = '0;
            end else begin
                for (int unsigned i = 0; i < 7; i++) begin
                    if (wr_cnt_q == 3'(i)) begin
                        buf_real_d[i] = smp_real;
                        buf_imag_d[i] = smp_imag;
                    end
                end
                if (bus.din_last) begin
                    // Early last: drop the partial frame; stale slots are
                    // overwritten before they can ever be presented.
                    frame_err_d = 1'b1;
                    wr_cnt_d    = '0;
                end else begin
                    wr_cnt_d = wr_cnt_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q    <= '0;
            en_q        <= 1'b0;
            frame_err_q <= 1'b0;
            for (int unsigned i = 0; i < 7; i++) begin
                buf_real_q[i] <= '0;
                buf_imag_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 8; i++) begin
                x_real_q[i] <= '0;
                x_imag_q[i] <= '0;
            end
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            en_q        <= en_d;
            frame_err_q <= frame_err_d;
            buf_real_q  <= buf_real_d;
            buf_imag_q  <= buf_imag_d;
            x_real_q    <= x_real_d;
            x_imag_q    <= x_imag_d;
        end
    end

    assign bus.en        = en_q;
    assign bus.frame_err = frame_err_q;

    assign bus.x0_real = x_real_q[0];
    assign bus.x1_real = x_real_q[1];
    assign bus.x2_real = x_real_q[2];
    assign bus.x3_real = x_real_q[3];
    assign bus.x4_real = x_real_q[4];
    assign bus.x5_real = x_real_q[5];
    assign bus.x6_real = x_real_q[6];
    assign bus.x7_real = x_real_q[7];
    assign bus.x0_imag = x_imag_q[0];
    assign bus.x1_imag = x_imag_q[1];
    assign bus.x2_imag = x_imag_q[2];
    assign bus.x3_imag = x_imag_q[3];
    assign bus.x4_imag = x_imag_q[4];
    assign bus.x5_imag = x_imag_q[5];
    assign bus.x6_imag = x_imag_q[6];
    assign bus.x7_imag = x_imag_q[7];

endmodule

// File: tb/tb_fft8_loader.sv
// tb_fft8_loader: table-driven, scoreboard-checked bench for fft8_loader.
// Works with or without FFT8_LOADER_SCALE_EN defined.
module tb_fft8_loader;

    logic clk;
    logic rstn;

    fft8_loader_if #(.DW(24)) bus ();

    fft8_loader #(.DW(24)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        last;
        logic [23:0] re;
        logic [23:0] im;
        logic        exp_en;
        logic        exp_err;
    } vec_t;

    typedef logic [7:0][23:0] row_t;
    typedef struct packed {
        row_t re;
        row_t im;
    } frame_t;

    vec_t   vecs[$];
    frame_t sb[$];
    frame_t cur_exp;

    int checks = 0;
    int errors = 0;

    // Independent reference state for the scoreboard
    int unsigned m_cnt;
    row_t        m_re;
    row_t        m_im;

    logic [23:0] dut_re [8];
    logic [23:0] dut_im [8];
    assign dut_re[0] = bus.x0_real;  assign dut_im[0] = bus.x0_imag;
    assign dut_re[1] = bus.x1_real;  assign dut_im[1] = bus.x1_imag;
    assign dut_re[2] = bus.x2_real;  assign dut_im[2] = bus.x2_imag;
    assign dut_re[3] = bus.x3_real;  assign dut_im[3] = bus.x3_imag;
    assign dut_re[4] = bus.x4_real;  assign dut_im[4] = bus.x4_imag;
    assign dut_re[5] = bus.x5_real;  assign dut_im[5] = bus.x5_imag;
    assign dut_re[6] = bus.x6_real;  assign dut_im[6] = bus.x6_imag;
    assign dut_re[7] = bus.x7_real;  assign dut_im[7] = bus.x7_imag;

    function automatic logic [23:0] scl(input logic [23:0] v);
`ifdef FFT8_LOADER_SCALE_EN
        return 24'($signed(v) >>> 3);
`else
        return v;
`endif
    endfunction

    function automatic logic [23:0] neg(input int v);
        return 24'(-v);
    endfunction

    task automatic add(input logic v, input logic last, input logic [23:0] re,
                       input logic [23:0] im, input logic e, input logic er);
        vec_t t;
        t.v = v; t.last = last; t.re = re; t.im = im; t.exp_en = e; t.exp_err = er;
        vecs.push_back(t);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, got, exp, $time);
        end
    endtask

    // Pops the scoreboard on en, then compares the held outputs.
    task automatic check_outputs();
        int bad;
        logic [23:0] g, e;
        if (bus.en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: en seen with no expected frame at %0t", $time);
            end else begin
                cur_exp = sb.pop_front();
            end
        end
        bad = -1;
        for (int i = 0; i < 16; i++) begin
            g = (i < 8) ? dut_re[i] : dut_im[i-8];
            e = (i < 8) ? cur_exp.re[i] : cur_exp.im[i-8];
            if (bad < 0 && g !== e) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            g = (bad < 8) ? dut_re[bad] : dut_im[bad-8];
            e = (bad < 8) ? cur_exp.re[bad] : cur_exp.im[bad-8];
            $display("FAIL outputs: x%0d_%s got %06h expected %06h at %0t",
                     bad % 8, (bad < 8) ? "real" : "imag", g, e, $time);
        end
    endtask

    task automatic step(input vec_t t);
        frame_t f;
        bus.din_valid = t.v;
        bus.din_last  = t.last;
        bus.din_real  = t.re;
        bus.din_imag  = t.im;
        if (t.v) begin
            if (m_cnt == 7) begin
                f.re = m_re; f.im = m_im;
                f.re[7] = scl(t.re);
                f.im[7] = scl(t.im);
                sb.push_back(f);
                m_cnt = 0;
            end else begin
                m_re[m_cnt] = scl(t.re);
                m_im[m_cnt] = scl(t.im);
                m_cnt = t.last ? 0 : m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        check_bit("en", bus.en, t.exp_en);
        check_bit("frame_err", bus.frame_err, t.exp_err);
        check_outputs();
    endtask

    task automatic sample(input logic [23:0] re, input logic [23:0] im, input logic last,
                          input logic e, input logic er);
        vec_t t;
        t.v = 1'b1; t.last = last; t.re = re; t.im = im; t.exp_en = e; t.exp_err = er;
        step(t);
    endtask

    initial begin
        vec_t idle;
        idle.v = 1'b0; idle.last = 1'b0; idle.re = '0; idle.im = '0;
        idle.exp_en = 1'b0; idle.exp_err = 1'b0;

        // Frame 1: 1..8 / -1..-8
        for (int i = 1; i <= 8; i++) add(1'b1, i == 8, 24'(i), neg(i), i == 8, 1'b0);
        // Frame 2: same, idle after sample 3 (en one cycle later)
        for (int i = 1; i <= 8; i++) begin
            add(1'b1, i == 8, 24'(i), neg(i), i == 8, 1'b0);
            if (i == 3) add(1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
        end
        // Two back-to-back frames 100..115
        for (int i = 0; i < 16; i++)
            add(1'b1, (i % 8) == 7, 24'(100 + i), neg(100 + i), (i % 8) == 7, 1'b0);
        add(1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
        // Early last on 5th sample, then a full frame of 7
        for (int i = 1; i <= 5; i++) add(1'b1, i == 5, 24'(50 + i), 24'(60 + i), 1'b0, i == 5);
        for (int i = 1; i <= 8; i++) add(1'b1, i == 8, 24'd7, 24'd7, i == 8, 1'b0);
        // Missing last: frame still emitted, err with en
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 24'(20 + i), neg(20 + i), i == 7, i == 7);
        // Sparse gaps everywhere, wrapping across a frame end
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 1'b0, 24'hABCDEF, 24'h123456, 1'b0, 1'b0);
            add(1'b1, i == 7, 24'h400000 + 24'(i), 24'hC00000 - 24'(i), i == 7, 1'b0);
        end

        bus.din_valid = 1'b0; bus.din_last = 1'b0;
        bus.din_real = '0;    bus.din_imag = '0;
        m_cnt = 0; m_re = '0; m_im = '0; cur_exp = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_en", bus.en, 1'b0);
        check_bit("reset_frame_err", bus.frame_err, 1'b0);
        check_outputs();
        rstn = 1'b1;

        foreach (vecs[k]) step(vecs[k]);

        // Reset mid-frame: 4 samples, reset, then 8 samples of 0x10
        for (int i = 0; i < 4; i++) sample(24'h000099, 24'h000088, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        m_cnt = 0; cur_exp = '0; sb.delete();
        check_bit("rst_mid_en", bus.en, 1'b0);
        check_outputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 7; i++) sample(24'h000010, 24'h000010, 1'b0, 1'b0, 1'b0);
        check_word("pre_en_x0_real", dut_re[0], 24'h000000);
        sample(24'h000010, 24'h000010, 1'b1, 1'b1, 1'b0);
`ifdef FFT8_LOADER_SCALE_EN
        check_word("rst_x0_real", dut_re[0], 24'h000002);
        check_word("rst_x7_real", dut_re[7], 24'h000002);
`else
        check_word("rst_x0_real", dut_re[0], 24'h000010);
        check_word("rst_x7_real", dut_re[7], 24'h000010);
`endif

        // Scaling boundary values
        for (int i = 0; i < 8; i++) sample(24'h7FFFF8, 24'h800000, i == 7, i == 7, 1'b0);
`ifdef FFT8_LOADER_SCALE_EN
        check_word("scale_x0_real", dut_re[0], 24'h0FFFFF);
        check_word("scale_x7_imag", dut_im[7], 24'hF00000);
`else
        check_word("scale_x0_real", dut_re[0], 24'h7FFFF8);
        check_word("scale_x7_imag", dut_im[7], 24'h800000);
`endif

        // Trailing idle: outputs hold, no stray pulses
        for (int i = 0; i < 4; i++) step(idle);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d frames pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft8_loader.md
# fft8_loader

Streaming input stage placed directly upstream of the 8-point parallel FFT core. It accepts one complex 24-bit sample per valid cycle and assembles eight consecutive samples into a frame. When the frame is complete, it presents all eight samples in natural order on parallel outputs, held stable, together with a one-cycle `en` launch pulse. It also checks frame alignment against a `din_last` marker and can optionally pre-scale the samples to prevent FFT overflow.

## Interface
- `DW`, 24, sample component width (real and imaginary each), two's complement.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous active-low reset.
- `din_valid`  in  1  input sample qualifier; one sample accepted per cycle it is high.
- `din_real`  in  DW  signed input real part.
- `din_imag`  in  DW  signed input imaginary part.
- `din_last`  in  1  marks the 8th sample of a frame; sampled only when `din_valid`=1.
- `en`  out  1  one-cycle pulse: x0..x7 hold a new frame; drives the FFT core `en`.
- `x0_real`..`x7_real`  out  DW each  frame sample n, real part (natural order, x0 = first accepted).
- `x0_imag`..`x7_imag`  out  DW each  frame sample n, imaginary part.
- `frame_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- 3-bit write index `wr_cnt`, reset to 0. Each cycle with `din_valid`=1, the sample is written to buffer slot `wr_cnt`, then `wr_cnt` increments (wraps 7→0).
- Frame completion is an accepted sample with `wr_cnt`=7. On that edge:
  - slots 0..6 plus the incoming sample are copied to the x0..x7 output registers;
  - `en` is set to 1 for exactly one cycle;
  - `wr_cnt` returns to 0.
- Outputs x0..x7 hold their value until the next frame completion; they are never partially updated.
- Internal buffer and output registers are separate, so the next frame's writes do not disturb the presented outputs.
- Framing checks, evaluated only on accepted samples:
  - `din_last`=1 with `wr_cnt`≠7: `frame_err` pulses the next cycle. The partial frame is discarded, no `en` is issued, and `wr_cnt` is forced to 0, so the next sample starts a new frame.
  - `din_last`=0 with `wr_cnt`=7: the frame is still emitted (`en` pulses) and `frame_err` pulses in the same cycle as `en`.
- `din_valid`=0 cycles (gaps) are legal anywhere in a frame. Index and buffer hold.
- No backpressure: the block is always ready. The downstream core accepts a launch every cycle.

## Timing
- Reset values: `en`=0, `frame_err`=0, all x*_real/x*_imag=0, `wr_cnt`=0, buffer=0.
- Reset asserted mid-frame discards the partial frame. After release, the first accepted sample is slot 0.
- Latency: `en` and the new x0..x7 appear on the cycle after the clock edge that accepts the 8th sample (1-cycle registered).
- Back-to-back frames with no gaps produce `en` every 8 cycles. The minimum `en` spacing is 8 cycles.
- `en` never stays high for 2 consecutive cycles.
- `frame_err` is never high for 2 consecutive cycles from a single violation. It is registered with the same 1-cycle latency as `en`.

## Configuration
- `FFT8_LOADER_SCALE_EN` defined:
  - each component is arithmetically right-shifted by 3 (sign-extended, truncation toward −∞) as it is written to the buffer;
  - this compensates for the ×8 worst-case gain of the 3-stage FFT, so the core's 24-bit outputs cannot overflow.
- Undefined: samples pass unmodified. Avoiding overflow is then the upstream's responsibility.

## Test plan
- Reset, then 8 consecutive samples real=1..8, imag=−1..−8, `din_last` on the 8th:
  - `en`=1 exactly one cycle after the 8th;
  - x0_real=1 … x7_real=8, x0_imag=−1 … x7_imag=−8;
  - `frame_err`=0.
- Same frame with one idle cycle inserted after sample 3: identical outputs, `en` delayed by one cycle.
- 16 back-to-back samples (two frames, values 100..115): `en` pulses at cycles 9 and 17. Outputs hold 100..107 between the pulses, then 108..115.
- `din_last` asserted on the 5th sample, then a full valid 8-sample frame of value 7:
  - `frame_err` pulses once and no `en` follows the aborted frame;
  - the next `en` presents all x*=7.
- `rstn` pulsed low after 4 samples, then 8 samples of 0x000010:
  - outputs are 0 until the new `en`;
  - then all x*_real=0x000010.
- With `FFT8_LOADER_SCALE_EN`: input real=0x7FFFF8 and imag=0x800000 give x*_real=0x0FFFFF and x*_imag=0xF00000. Without the macro, the values pass unchanged.
